demux_stream: RTL and testbench

Parametrised 1-to-N stream demultiplexer, the successor to the combinational 1-to-8 demux. A single valid/ready input stream is steered to one of N output channels, either by an explicit select or by an internal round-robin pointer. Each channel owns a one-entry registered holding slot, so a stalled consumer blocks only traffic addressed to it. It sits between a single producer and N independent consumers in the datapath.

---
 rtl/demux_pkg.sv | 14 +
 rtl/demux_slot.sv | 42 ++++
 rtl/demux_stream.sv | 100 ++++++++++
 tb/tb_demux_stream.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the stream demultiplexer: routing mode encodings
// and the saturating increment used by the drop counter.
package demux_pkg;

  localparam logic MODE_SELECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Callers zero-extend into 32 bits and truncate the result back to their width.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    return (value >= max_value) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single output channel.
// A load wins over a drain in the same cycle, which keeps the slot full.
module demux_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic [W-1:0] data_o,
  output logic         valid_o
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/demux_stream.sv
// 1-to-N valid/ready stream demultiplexer with per-channel holding slots,
// explicit-select or round-robin routing, and a drop counter for bad selects.
module demux_stream
  import demux_pkg::*;
#(
  parameter  int N  = 8,
  parameter  int W  = 8,
  parameter  int CW = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mode,
  input  logic [W-1:0]   din,
  input  logic [SW-1:0]  sel,
  input  logic           din_valid,
  output logic           din_ready,
  output logic [N*W-1:0] dout,
  output logic [N-1:0]   dout_valid,
  input  logic [N-1:0]   dout_ready,
  output logic [SW-1:0]  rr_ptr,
  output logic [CW-1:0]  drop_cnt
);

  // Per-channel status is padded to the full select range so any tgt indexes safely.
  localparam int NP = 1 << SW;

  logic [SW-1:0] tgt;
  logic [NP-1:0] chan_exists;
  logic [NP-1:0] full_ext;
  logic [NP-1:0] ready_ext;
  logic          tgt_ok;
  logic          accept;
  logic          do_load;
  logic          do_drop;
  logic [SW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  generate
    for (genvar gi = 0; gi < NP; gi++) begin : g_ext
      assign chan_exists[gi] = (gi < N);
      if (gi < N) begin : g_real
        assign full_ext[gi]  = dout_valid[gi];
        assign ready_ext[gi] = dout_ready[gi];
      end else begin : g_pad
        assign full_ext[gi]  = 1'b0;
        assign ready_ext[gi] = 1'b0;
      end
    end
  endgenerate

  assign tgt    = (mode == MODE_RR) ? rr_ptr_q : sel;
  assign tgt_ok = chan_exists[tgt];

  // Depends only on routing state and consumer readiness, never on din_valid.
  assign din_ready = !tgt_ok || !full_ext[tgt] || ready_ext[tgt];

  assign accept  = din_valid && din_ready;
  assign do_load = accept && tgt_ok;
  assign do_drop = accept && !tgt_ok;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slot
      demux_slot #(.W(W)) u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (do_load && (tgt == SW'(gi))),
        .data_i  (din),
        .ready_i (dout_ready[gi]),
        .data_o  (dout[gi*W +: W]),
        .valid_o (dout_valid[gi])
      );
    end
  endgenerate

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    drop_cnt_d = drop_cnt_q;
    if (do_load && (mode == MODE_RR)) begin
      rr_ptr_d = (rr_ptr_q == SW'(N - 1)) ? '0 : rr_ptr_q + 1'b1;
    end
    if (do_drop) begin
      drop_cnt_d = CW'(sat_inc(32'(drop_cnt_q), 32'({CW{1'b1}})));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign rr_ptr   = rr_ptr_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_demux_stream.sv
// Directed bench for demux_stream: an N=8 instance for routing, backpressure and
// reset, plus two N=6 instances (CW=8 and CW=2) for out-of-range drops.
module tb_demux_stream;

  logic clk;
  logic rst_n;

  logic        mode8, valid8, ready8;
  logic [7:0]  din8;
  logic [2:0]  sel8, rr8;
  logic [63:0] dout8;
  logic [7:0]  dvalid8, dready8, drop8;

  logic        mode6, valid6, rdy6a, rdy6b;
  logic [7:0]  din6;
  logic [2:0]  sel6, rr6a, rr6b;
  logic [5:0]  dready6, dval6a, dval6b;
  logic [47:0] dout6a, dout6b;
  logic [7:0]  drop6a;
  logic [1:0]  drop6b;

  int n_checks = 0;
  int n_fail   = 0;

  demux_stream #(.N(8), .W(8), .CW(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .mode(mode8), .din(din8), .sel(sel8),
    .din_valid(valid8), .din_ready(ready8), .dout(dout8), .dout_valid(dvalid8),
    .dout_ready(dready8), .rr_ptr(rr8), .drop_cnt(drop8)
  );

  demux_stream #(.N(6), .W(8), .CW(8)) u_dut6a (
    .clk(clk), .rst_n(rst_n), .mode(mode6), .din(din6), .sel(sel6),
    .din_valid(valid6), .din_ready(rdy6a), .dout(dout6a), .dout_valid(dval6a),
    .dout_ready(dready6), .rr_ptr(rr6a), .drop_cnt(drop6a)
  );

  demux_stream #(.N(6), .W(8), .CW(2)) u_dut6b (
    .clk(clk), .rst_n(rst_n), .mode(mode6), .din(din6), .sel(sel6),
    .din_valid(valid6), .din_ready(rdy6b), .dout(dout6b), .dout_valid(dval6b),
    .dout_ready(dready6), .rr_ptr(rr6b), .drop_cnt(drop6b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  typedef struct {
    logic       mode;
    logic [2:0] sel;
    logic [7:0] din;
    int         exp_ch;
    logic [2:0] exp_rr;
  } vec_t;

  vec_t vecs[18];

  initial begin
    // SELECT sweep: one beat per channel, pointer untouched
    for (int i = 0; i < 8; i++) begin
      vecs[i].mode   = 1'b0;
      vecs[i].sel    = 3'(i);
      vecs[i].din    = 8'(8'hA0 + i);
      vecs[i].exp_ch = i;
      vecs[i].exp_rr = 3'd0;
    end
    // ROUND_ROBIN: 10 beats with wrap, sel deliberately nonzero and ignored
    for (int i = 0; i < 10; i++) begin
      vecs[8+i].mode   = 1'b1;
      vecs[8+i].sel    = 3'd5;
      vecs[8+i].din    = 8'(i);
      vecs[8+i].exp_ch = i % 8;
      vecs[8+i].exp_rr = 3'((i + 1) % 8);
    end

    rst_n = 1'b0;
    mode8 = 1'b0; din8 = '0; sel8 = '0; valid8 = 1'b0; dready8 = 8'hFF;
    mode6 = 1'b0; din6 = '0; sel6 = '0; valid6 = 1'b0; dready6 = 6'h3F;
    #1;
    check("reset_valid", 64'(dvalid8), 64'h0);
    check("reset_dout", dout8, 64'h0);
    check("reset_rr", 64'(rr8), 64'h0);
    check("reset_drop", 64'(drop8), 64'h0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      mode8 = vecs[i].mode; sel8 = vecs[i].sel; din8 = vecs[i].din; valid8 = 1'b1;
      #1;
      check("vec_ready", 64'(ready8), 64'h1);
      check("vec_pre_valid", 64'(dvalid8[vecs[i].exp_ch]), 64'h0);
      @(posedge clk); #1;
      check("vec_valid", 64'(dvalid8[vecs[i].exp_ch]), 64'h1);
      check("vec_data", 64'(dout8[vecs[i].exp_ch*8 +: 8]), 64'(vecs[i].din));
      check("vec_rr", 64'(rr8), 64'(vecs[i].exp_rr));
    end
    @(negedge clk);
    valid8 = 1'b0;
    check("vec_drop_zero", 64'(drop8), 64'h0);

    // Backpressure on channel 3, then drain and load in the same cycle
    @(negedge clk);
    mode8 = 1'b0; sel8 = 3'd3; din8 = 8'h11; valid8 = 1'b1; dready8 = 8'hF7;
    #1; check("bp_ready_first", 64'(ready8), 64'h1);
    @(posedge clk); #1;
    check("bp_data_first", 64'(dout8[31:24]), 64'h11);
    @(negedge clk);
    din8 = 8'h22;
    #1; check("bp_ready_stall", 64'(ready8), 64'h0);
    @(posedge clk); #1;
    check("bp_data_held", 64'(dout8[31:24]), 64'h11);
    check("bp_valid_held", 64'(dvalid8[3]), 64'h1);
    @(negedge clk);
    dready8 = 8'hFF;
    #1; check("bp_ready_release", 64'(ready8), 64'h1);
    @(posedge clk); #1;
    check("bp_data_second", 64'(dout8[31:24]), 64'h22);
    check("bp_valid_second", 64'(dvalid8[3]), 64'h1);
    @(negedge clk);
    valid8 = 1'b0;
    @(posedge clk); #1;
    check("bp_drained", 64'(dvalid8[3]), 64'h0);
    check("bp_data_kept", 64'(dout8[31:24]), 64'h22);

    // Round-robin stall: fill slot 2 via SELECT, then RR targets it (rr=2)
    @(negedge clk);
    dready8 = 8'hFB; mode8 = 1'b0; sel8 = 3'd2; din8 = 8'h55; valid8 = 1'b1;
    @(posedge clk); #1;
    check("rr_fill_slot2", 64'(dvalid8[2]), 64'h1);
    check("rr_kept_after_select", 64'(rr8), 64'h2);
    @(negedge clk);
    mode8 = 1'b1; sel8 = 3'd5; din8 = 8'h66;
    #1; check("rr_stall_ready", 64'(ready8), 64'h0);
    @(posedge clk); #1;
    check("rr_stall_ptr", 64'(rr8), 64'h2);
    check("rr_stall_data", 64'(dout8[23:16]), 64'h55);
    check("rr_stall_others", 64'(dvalid8), 64'h04);
    @(negedge clk);
    dready8 = 8'hFF;
    #1; check("rr_release_ready", 64'(ready8), 64'h1);
    @(posedge clk); #1;
    check("rr_release_data", 64'(dout8[23:16]), 64'h66);
    check("rr_release_valid", 64'(dvalid8[2]), 64'h1);
    check("rr_release_ptr", 64'(rr8), 64'h3);
    @(negedge clk);
    valid8 = 1'b0;

    // N=6: out-of-range selects are accepted and dropped
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mode6 = 1'b0; sel6 = (i % 2 == 0) ? 3'd6 : 3'd7; din6 = 8'(8'h5A + i); valid6 = 1'b1;
      #1;
      check("drop_ready_a", 64'(rdy6a), 64'h1);
      check("drop_ready_b", 64'(rdy6b), 64'h1);
      @(posedge clk); #1;
      check("drop_no_valid", 64'(dval6a), 64'h0);
      if (i == 2) begin
        check("drop_cnt3_a", 64'(drop6a), 64'h3);
        check("drop_cnt3_b", 64'(drop6b), 64'h3);
      end
    end
    check("drop_cnt5_a", 64'(drop6a), 64'h5);
    check("drop_sat_b", 64'(drop6b), 64'h3);
    @(negedge clk);
    sel6 = 3'd5; din6 = 8'hC5;
    @(posedge clk); #1;
    check("n6_last_valid", 64'(dval6a), 64'h20);
    check("n6_last_data", 64'(dout6a[47:40]), 64'hC5);
    check("n6_drop_unchanged", 64'(drop6a), 64'h5);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      mode6 = 1'b1; din6 = 8'(8'h60 + i);
      @(posedge clk); #1;
      check("n6_rr_ptr", 64'(rr6a), 64'((i + 1) % 6));
      check("n6_rr_data", 64'(dout6a[i*8 +: 8]), 64'(8'h60 + i));
    end
    @(negedge clk);
    valid6 = 1'b0;

    // Async reset mid-stream with slots 1 and 4 held and rr=5
    @(negedge clk);
    dready8 = 8'hED; mode8 = 1'b1; din8 = 8'h73; valid8 = 1'b1;
    @(negedge clk);
    din8 = 8'h74;
    @(negedge clk);
    mode8 = 1'b0; sel8 = 3'd1; din8 = 8'h71;
    @(posedge clk); #1;
    check("pre_rst_valid", 64'(dvalid8), 64'h12);
    check("pre_rst_ptr", 64'(rr8), 64'h5);
    @(negedge clk);
    valid8 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(dvalid8), 64'h0);
    check("async_rst_dout", dout8, 64'h0);
    check("async_rst_ptr", 64'(rr8), 64'h0);
    check("async_rst_drop8", 64'(drop8), 64'h0);
    check("async_rst_drop6a", 64'(drop6a), 64'h0);
    check("async_rst_drop6b", 64'(drop6b), 64'h0);
    @(negedge clk);
    rst_n = 1'b1; dready8 = 8'hFF; mode8 = 1'b1; din8 = 8'h99; valid8 = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid", 64'(dvalid8), 64'h01);
    check("post_rst_data", 64'(dout8[7:0]), 64'h99);
    check("post_rst_ptr", 64'(rr8), 64'h1);
    @(negedge clk);
    valid8 = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
